isqrt_pipe_n: RTL
=================

ISQRT_PIPE_N -- requirements
Module: isqrt_pipe_n

Interface
REQ-001 SHALL have parameter WIDTH, default 16: radicand width in bits; even, ≥4; an odd value or a value <4 SHALL be a synthesis/elaboration error.
REQ-002 SHALL have derived localparam N = WIDTH/2: root width in bits and iteration count.
REQ-003 SHALL have port clock  input  1: single clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port start_in  input  1: request; sampled only in IDLE.
REQ-006 SHALL have port input_x  input  WIDTH: unsigned radicand; sampled on the accepting edge only.
REQ-007 SHALL have port busy  output  1: high while a computation is in progress.
REQ-008 SHALL have port done  output  1: one-cycle pulse marking new valid results.
REQ-009 SHALL have port output_x  output  N: floor(sqrt(radicand)).
REQ-010 SHALL have port remainder  output  N+1: radicand − output_x².

Function
REQ-011 SHALL implement states IDLE and RUN, plus an N-step iteration counter.
REQ-012 IDLE with start_in=1 at edge k: SHALL latch input_x, clear the working root, set the bit mask to 1<<(WIDTH−2), enter RUN, and drive busy=1 after edge k.
REQ-013 IDLE with start_in=0: SHALL hold state; output_x and remainder SHALL hold their last values.
REQ-014 Each RUN edge (k+1 … k+N) SHALL do one restoring step with t = op − (res + mask) evaluated at WIDTH+1 bits:
- t ≥ 0: op ← t, res ← (res>>1) + mask;
- otherwise: res ← res>>1.
- Then in both cases: mask ← mask>>2.
REQ-015 At edge k+N+1: SHALL load output_x ← res[N−1:0], load remainder ← op[N:0], assert done=1 for exactly that cycle, drop busy, and return to IDLE.
REQ-016 Latency SHALL be N+1 cycles from the accepting edge to the done-visible cycle, fixed and independent of data.
REQ-017 start_in SHALL be ignored while busy=1; input_x changes during RUN SHALL have no effect.
REQ-018 start_in=1 in the cycle done=1 SHALL be accepted, since the block is in IDLE, giving back-to-back throughput of one result per N+1 cycles.
REQ-019 done and busy SHALL never both be 1.
REQ-020 Internal arithmetic SHALL not overflow for any WIDTH-bit input: remainder ≤ 2·output_x ≤ 2^(N+1)−2.

Reset
REQ-021 reset=1 at any edge, including mid-RUN, SHALL force IDLE, busy=0, done=0, output_x=0, remainder=0, and clear the internal op, res, mask and counter.
REQ-022 reset SHALL override a simultaneous start_in; no computation starts that cycle.
REQ-023 The first start_in is accepted on the first edge with reset=0.

Verification
REQ-024 The bench SHALL cover these WIDTH=16 directed cases, each with done exactly 9 cycles after acceptance:
- x=0 → output_x=0, remainder=0.
- x=144 → 12, 0.
- x=143 → 11, 22.
- x=65535 → 255, 510.
REQ-025 WIDTH=16, start x=1000, then start_in=1 with x=4 during busy → single result 31, 39; no second done.
REQ-026 WIDTH=16, start x=50000, reset asserted on the 4th RUN cycle → all outputs 0, busy=0, no done; next start x=81 → 9, 0.
REQ-027 WIDTH=16, start x=255 (→ 15, 30), then start_in=1 with x=256 in the done cycle → next done exactly 9 cycles later with 16, 0.
REQ-028 WIDTH=8 instance: exhaustive sweep of 0…255 against a floor-sqrt model; every result holds output_x² + remainder = x and latency = 5 cycles.

Source files
------------

// File: rtl/isqrt_pipe_n.sv
// Sequential restoring integer square root.
// Accepts a WIDTH-bit radicand in IDLE, iterates N = WIDTH/2 restoring steps
// in RUN, then publishes floor(sqrt(x)) and x - root^2 with a one-cycle done.
// Latency from accepting edge to done-visible cycle is always N+1 clocks.
//
// state | meaning
// IDLE  | waiting for start_in; results hold their last values
// RUN   | N restoring steps, then one finalize edge that loads results

module isqrt_pipe_n #(
    parameter int WIDTH = 16,
    localparam int N = WIDTH / 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_in,
    input  logic [WIDTH-1:0] input_x,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     output_x,
    output logic [N:0]       remainder
);

    // Reject odd or too-narrow radicand widths at elaboration.
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $error("isqrt_pipe_n: WIDTH must be even and at least 4");
    end

    // Step counter must hold the value N itself.
    localparam int CW = $clog2(N + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   op;
    logic [WIDTH-1:0]   res;
    logic [WIDTH-1:0]   mask;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     trial;

    // Trial subtraction one bit wider than the operands; the MSB is the sign.
    always_comb begin
        trial = {1'b0, op} - ({1'b0, res} + {1'b0, mask});
    end

    // Control FSM, datapath iteration and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            output_x  <= '0;
            remainder <= '0;
            op        <= '0;
            res       <= '0;
            mask      <= '0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        op    <= input_x;
                        res   <= '0;
                        mask  <= {2'b01, {(WIDTH-2){1'b0}}};
                        cnt   <= CW'(N);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        // One restoring step; keep the subtraction only if non-negative.
                        if (!trial[WIDTH]) begin
                            op  <= trial[WIDTH-1:0];
                            res <= (res >> 1) + mask;
                        end else begin
                            res <= res >> 1;
                        end
                        mask <= mask >> 2;
                        cnt  <= cnt - CW'(1);
                    end else begin
                        // Terminal count: remainder never exceeds 2*root, so N+1 bits suffice.
                        output_x  <= res[N-1:0];
                        remainder <= op[N:0];
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
